// File: rtl/mmss_timer.sv
// mmss_timer: MM:SS BCD up/down time source with load/start/stop/clear control.
// Define MMSS_ALARM_EN to add the al_min/al_sec alarm comparator and alarm pulse.
module mmss_timer #(
   parameter int TICK_DIV = 50000000,
   parameter int CNT_W    = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       clear,
   input  logic       load,
   input  logic [3:0] ld_min_t,
   input  logic [3:0] ld_min_u,
   input  logic [3:0] ld_sec_t,
   input  logic [3:0] ld_sec_u,
   input  logic       down,
`ifdef MMSS_ALARM_EN
   input  logic [7:0] al_min,
   input  logic [7:0] al_sec,
   output logic       alarm,
`endif
   output logic [3:0] digit1,
   output logic [3:0] digit2,
   output logic [3:0] digit3,
   output logic [3:0] digit4,
   output logic       running,
   output logic       done,
   output logic       wrap,
   output logic       load_err
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] pre_reg, pre_next;
   logic [15:0]      dig_reg, dig_next;
   logic             running_reg, running_next;
   logic             done_reg, done_next;
   logic             wrap_reg, wrap_next;
   logic             lerr_reg, lerr_next;
`ifdef MMSS_ALARM_EN
   logic             alarm_reg, alarm_next;
`endif

   logic [15:0] ld_val, inc_val, dec_val, step_val;
   logic [4:0]  carry;
   logic [3:0]  borrow;
   logic [3:0]  ld_ok;
   logic        step;
   logic        dig_zero;

   // Digit vector layout is {min_t, min_u, sec_t, sec_u}; digit gi lives at [4*gi +: 4].
   assign ld_val    = {ld_min_t, ld_min_u, ld_sec_t, ld_sec_u};
   assign carry[0]  = 1'b1;
   assign borrow[0] = 1'b1;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_digit
         localparam logic [3:0] DMAX = (gi % 2 == 1) ? 4'd5 : 4'd9;
         logic [3:0] cur;
         assign cur = dig_reg[4*gi +: 4];
         assign inc_val[4*gi +: 4] = !carry[gi]  ? cur :
                                     (cur == DMAX) ? 4'd0 : cur + 4'd1;
         assign dec_val[4*gi +: 4] = !borrow[gi] ? cur :
                                     (cur == 4'd0) ? DMAX : cur - 4'd1;
         assign carry[gi+1] = carry[gi] && (cur == DMAX);
         if (gi < 3) begin : g_borrow
            assign borrow[gi+1] = borrow[gi] && (cur == 4'd0);
         end
         assign ld_ok[gi] = (ld_val[4*gi +: 4] <= DMAX);
      end
   endgenerate

   assign step_val = down ? dec_val : inc_val;
   assign step     = (state_reg == RUN) && (pre_reg == CNT_W'(TICK_DIV - 1));
   assign dig_zero = (dig_reg == 16'h0000);

   always_comb begin
      state_next = state_reg;
      pre_next   = pre_reg;
      dig_next   = dig_reg;
      done_next  = 1'b0;
      wrap_next  = 1'b0;
      lerr_next  = 1'b0;
`ifdef MMSS_ALARM_EN
      alarm_next = 1'b0;
`endif
      if (clear) begin
         dig_next   = 16'h0000;
         pre_next   = '0;
         state_next = IDLE;
      end else if (load) begin
         if (&ld_ok) begin
            dig_next   = ld_val;
            pre_next   = '0;
            state_next = IDLE;
         end else begin
            lerr_next = 1'b1;
         end
      end else if (stop) begin
         // The prescaler holds its value so a resume finishes the interrupted second.
         if (state_reg == RUN) state_next = PAUSE;
      end else begin
         case (state_reg)
            IDLE, PAUSE: begin
               if (start) begin
                  if (down && dig_zero) begin
                     state_next = EXPIRED;
                     done_next  = 1'b1;
                  end else begin
                     state_next = RUN;
                  end
               end
            end
            RUN: begin
               if (step) begin
                  pre_next = '0;
                  dig_next = step_val;
                  if (down) begin
                     if (dec_val == 16'h0000) begin
                        done_next  = 1'b1;
                        state_next = EXPIRED;
                     end
                  end else begin
                     wrap_next = carry[4];
                  end
`ifdef MMSS_ALARM_EN
                  alarm_next = (step_val == {al_min, al_sec});
`endif
               end else begin
                  pre_next = pre_reg + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
      running_next = (state_next == RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         pre_reg     <= '0;
         dig_reg     <= 16'h0000;
         running_reg <= 1'b0;
         done_reg    <= 1'b0;
         wrap_reg    <= 1'b0;
         lerr_reg    <= 1'b0;
`ifdef MMSS_ALARM_EN
         alarm_reg   <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         pre_reg     <= pre_next;
         dig_reg     <= dig_next;
         running_reg <= running_next;
         done_reg    <= done_next;
         wrap_reg    <= wrap_next;
         lerr_reg    <= lerr_next;
`ifdef MMSS_ALARM_EN
         alarm_reg   <= alarm_next;
`endif
      end
   end

   assign digit1   = dig_reg[3:0];
   assign digit2   = dig_reg[7:4];
   assign digit3   = dig_reg[11:8];
   assign digit4   = dig_reg[15:12];
   assign running  = running_reg;
   assign done     = done_reg;
   assign wrap     = wrap_reg;
   assign load_err = lerr_reg;
`ifdef MMSS_ALARM_EN
   assign alarm    = alarm_reg;
`endif

endmodule

// File: tb/tb_mmss_timer.sv
// Self-checking bench for mmss_timer (TICK_DIV = 4): vector table plus hand-written
// pause, reset and alarm sequences; expectations travel through a scoreboard queue.
`timescale 1ns/1ps
module tb_mmss_timer;
   localparam int TICK_DIV = 4;
   localparam int CNT_W    = 4;

   logic       clk = 1'b0;
   logic       rst, start, stop, clear, load, down;
   logic [3:0] ld_min_t, ld_min_u, ld_sec_t, ld_sec_u;
   logic [3:0] digit1, digit2, digit3, digit4;
   logic       running, done, wrap, load_err;
`ifdef MMSS_ALARM_EN
   logic [7:0] al_min, al_sec;
   logic       alarm;
`endif

   always #5 clk = ~clk;

   mmss_timer #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .load(load),
      .ld_min_t(ld_min_t), .ld_min_u(ld_min_u), .ld_sec_t(ld_sec_t), .ld_sec_u(ld_sec_u),
      .down(down),
`ifdef MMSS_ALARM_EN
      .al_min(al_min), .al_sec(al_sec), .alarm(alarm),
`endif
      .digit1(digit1), .digit2(digit2), .digit3(digit3), .digit4(digit4),
      .running(running), .done(done), .wrap(wrap), .load_err(load_err)
   );

   typedef struct {
      logic        st, sp, cl, lo, dir;
      logic [15:0] ldv;
      int          idle;
      logic [15:0] mmss;
      logic        run, dn, wr, le;
   } vec_t;

   typedef struct packed {
      logic [15:0] mmss;
      logic        run, dn, wr, le;
   } exp_t;

   exp_t sbq[$];
   int   total  = 0;
   int   passed = 0;
   vec_t tbl [30];

   function automatic vec_t mk(input logic st, sp, cl, lo, dir, input logic [15:0] ldv,
                               input int idle, input logic [15:0] mmss,
                               input logic run, dn, wr, le);
      vec_t v;
      v.st = st; v.sp = sp; v.cl = cl; v.lo = lo; v.dir = dir;
      v.ldv = ldv; v.idle = idle; v.mmss = mmss;
      v.run = run; v.dn = dn; v.wr = wr; v.le = le;
      return v;
   endfunction

   task automatic check_pop(input string nm);
      exp_t e, a;
      total++;
      if (sbq.size() == 0) begin
         $display("FAIL %s: scoreboard empty, nothing to compare", nm);
         return;
      end
      e = sbq.pop_front();
      a = {digit4, digit3, digit2, digit1, running, done, wrap, load_err};
      if (a === e) begin
         passed++;
         $display("ok   %s: mmss=%h run=%b done=%b wrap=%b lerr=%b",
                  nm, a.mmss, a.run, a.dn, a.wr, a.le);
      end else begin
         $display("FAIL %s: got mmss=%h run=%b done=%b wrap=%b lerr=%b, expected mmss=%h run=%b done=%b wrap=%b lerr=%b",
                  nm, a.mmss, a.run, a.dn, a.wr, a.le, e.mmss, e.run, e.dn, e.wr, e.le);
      end
   endtask

   // Drive the controls for one edge, idle for v.idle more edges, then compare.
   task automatic apply(input vec_t v, input string nm);
      start = v.st; stop = v.sp; clear = v.cl; load = v.lo; down = v.dir;
      {ld_min_t, ld_min_u, ld_sec_t, ld_sec_u} = v.ldv;
      sbq.push_back({v.mmss, v.run, v.dn, v.wr, v.le});
      @(negedge clk);
      start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
      repeat (v.idle) @(negedge clk);
      check_pop(nm);
   endtask

   task automatic check_bit(input string nm, input logic act, input logic req);
      total++;
      if (act === req) begin
         passed++;
         $display("ok   %s: %b", nm, act);
      end else begin
         $display("FAIL %s: got %b, expected %b", nm, act, req);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0; down = 1'b0;
      {ld_min_t, ld_min_u, ld_sec_t, ld_sec_u} = 16'h0000;
`ifdef MMSS_ALARM_EN
      al_min = 8'h00; al_sec = 8'h03;
`endif
      //            st sp cl lo dn  ldv      idle mmss     run done wrap lerr
      tbl[0]  = mk(1, 0, 0, 0, 0, 16'h0000, 0,   16'h0000, 1, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 0, 0, 16'h0000, 2,   16'h0000, 1, 0, 0, 0);
      tbl[2]  = mk(0, 0, 0, 0, 0, 16'h0000, 0,   16'h0001, 1, 0, 0, 0);
      tbl[3]  = mk(0, 0, 0, 0, 0, 16'h0000, 159, 16'h0041, 1, 0, 0, 0);
      tbl[4]  = mk(0, 0, 0, 1, 0, 16'h5958, 0,   16'h5958, 0, 0, 0, 0);
      tbl[5]  = mk(1, 0, 0, 0, 0, 16'h0000, 0,   16'h5958, 1, 0, 0, 0);
      tbl[6]  = mk(0, 0, 0, 0, 0, 16'h0000, 3,   16'h5959, 1, 0, 0, 0);
      tbl[7]  = mk(0, 0, 0, 0, 0, 16'h0000, 2,   16'h5959, 1, 0, 0, 0);
      tbl[8]  = mk(0, 0, 0, 0, 0, 16'h0000, 0,   16'h0000, 1, 0, 1, 0);
      tbl[9]  = mk(0, 0, 0, 0, 0, 16'h0000, 0,   16'h0000, 1, 0, 0, 0);
      tbl[10] = mk(0, 0, 0, 1, 1, 16'h0002, 0,   16'h0002, 0, 0, 0, 0);
      tbl[11] = mk(1, 0, 0, 0, 1, 16'h0000, 0,   16'h0002, 1, 0, 0, 0);
      tbl[12] = mk(0, 0, 0, 0, 1, 16'h0000, 3,   16'h0001, 1, 0, 0, 0);
      tbl[13] = mk(0, 0, 0, 0, 1, 16'h0000, 3,   16'h0000, 0, 1, 0, 0);
      tbl[14] = mk(0, 0, 0, 0, 1, 16'h0000, 0,   16'h0000, 0, 0, 0, 0);
      tbl[15] = mk(1, 0, 0, 0, 1, 16'h0000, 0,   16'h0000, 0, 0, 0, 0);
      tbl[16] = mk(1, 0, 0, 0, 0, 16'h0000, 4,   16'h0000, 0, 0, 0, 0);
      tbl[17] = mk(0, 0, 0, 1, 0, 16'h1234, 0,   16'h1234, 0, 0, 0, 0);
      tbl[18] = mk(0, 0, 0, 1, 0, 16'h1264, 0,   16'h1234, 0, 0, 0, 1);
      tbl[19] = mk(0, 0, 0, 0, 0, 16'h0000, 0,   16'h1234, 0, 0, 0, 0);
      tbl[20] = mk(1, 0, 0, 0, 0, 16'h0000, 0,   16'h1234, 1, 0, 0, 0);
      tbl[21] = mk(0, 0, 1, 1, 0, 16'h0959, 0,   16'h0000, 0, 0, 0, 0);
      tbl[22] = mk(0, 0, 0, 0, 0, 16'h0000, 4,   16'h0000, 0, 0, 0, 0);
      tbl[23] = mk(1, 1, 0, 0, 0, 16'h0000, 4,   16'h0000, 0, 0, 0, 0);
      tbl[24] = mk(0, 0, 0, 1, 0, 16'h1000, 0,   16'h1000, 0, 0, 0, 0);
      tbl[25] = mk(1, 0, 0, 0, 1, 16'h0000, 4,   16'h0959, 1, 0, 0, 0);
      tbl[26] = mk(0, 0, 0, 0, 1, 16'h0000, 3,   16'h0958, 1, 0, 0, 0);
      tbl[27] = mk(0, 0, 0, 0, 0, 16'h0000, 3,   16'h0959, 1, 0, 0, 0);
      tbl[28] = mk(0, 1, 0, 0, 0, 16'h0000, 0,   16'h0959, 0, 0, 0, 0);
      tbl[29] = mk(1, 0, 0, 0, 0, 16'h0000, 4,   16'h1000, 1, 0, 0, 0);

      repeat (2) @(negedge clk);
      sbq.push_back({16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
      check_pop("reset");
      rst = 1'b0;

      // Down-start at 00:00 from IDLE goes straight to EXPIRED with a done pulse.
      apply(mk(1, 0, 0, 0, 1, 16'h0000, 0, 16'h0000, 0, 1, 0, 0), "zero_down_start");
      apply(mk(0, 0, 0, 0, 1, 16'h0000, 0, 16'h0000, 0, 0, 0, 0), "zero_down_after");
      apply(mk(0, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0), "clear_expired");

      for (int i = 0; i < 30; i++) apply(tbl[i], $sformatf("vec%0d", i));

      // Pause on prescaler count 2, hold, then resume: step lands 2 edges after re-entry.
      apply(mk(0, 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0), "pause_load");
      apply(mk(1, 0, 0, 0, 0, 16'h0000, 2, 16'h0000, 1, 0, 0, 0), "pause_run");
      apply(mk(0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0), "pause_stop");
      for (int i = 0; i < 9; i++)
         apply(mk(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0), $sformatf("pause_hold%0d", i));
      apply(mk(1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0), "resume_entry");
      apply(mk(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0), "resume_plus1");
      apply(mk(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0001, 1, 0, 0, 0), "resume_step");

      // Synchronous reset mid-count.
      apply(mk(0, 0, 0, 0, 0, 16'h0000, 2, 16'h0001, 1, 0, 0, 0), "prerst_run");
      rst = 1'b1;
      sbq.push_back({16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      rst = 1'b0;
      check_pop("rst_midcount");
      apply(mk(0, 0, 0, 0, 0, 16'h0000, 5, 16'h0000, 0, 0, 0, 0), "post_rst_idle");

`ifdef MMSS_ALARM_EN
      begin
         int          hits;
         logic [15:0] hit_val;
         hits = 0;
         hit_val = 16'hffff;
         apply(mk(0, 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0), "alarm_load0");
         check_bit("alarm_after_load0", alarm, 1'b0);
         apply(mk(1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0), "alarm_start");
         for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (alarm) begin
               hits++;
               hit_val = {digit4, digit3, digit2, digit1};
            end
         end
         check_bit("alarm_once", hits == 1, 1'b1);
         check_bit("alarm_at_0003", hit_val == 16'h0003, 1'b1);
         apply(mk(0, 0, 0, 1, 0, 16'h0003, 0, 16'h0003, 0, 0, 0, 0), "alarm_load3");
         check_bit("alarm_after_load3", alarm, 1'b0);
      end
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
